// File: rtl/fan_pwm_timebase.sv
// Prescaled 0..period up-counter with double-buffered duty/period shadows feeding the fan
// comparator; config changes arrive over valid/ready and take effect only at a wrap or while idle.
module fan_pwm_timebase #(
   parameter int unsigned N     = 20,
   parameter int unsigned PRE_W = 8
) (
   input  logic             clk,
   input  logic             reset_p,
   input  logic             enable,
   input  logic [PRE_W-1:0] prescale,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [N-1:0]     cfg_period,
   input  logic [N-1:0]     cfg_duty,
   output logic [N-1:0]     cnt,
   output logic [N-1:0]     duty_q,
   output logic [N-1:0]     period_q,
   output logic             period_end,
   output logic             pwm_out
);

   typedef enum logic [0:0] {StIdle, StRun} state_e;

   state_e           state_q, state_d;
   logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
   logic [N-1:0]     cnt_q, cnt_d;
   logic [N-1:0]     duty_act_q, duty_act_d;
   logic [N-1:0]     period_act_q, period_act_d;
   logic [N-1:0]     pend_duty_q, pend_duty_d;
   logic [N-1:0]     pend_period_q, pend_period_d;
   logic             pending_q, pending_d;
   logic             period_end_q, period_end_d;
   logic             pwm_q, pwm_d;

   logic run;
   logic tick;
   logic wrap;
   logic accept;
   logic apply;

   // Next state is decided from enable in the same cycle, so the datapath follows state_d.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (enable)  state_d = StRun;
         StRun:   if (!enable) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // >= rather than == so lowering prescale below pre_cnt never stalls for a full wrap.
   always_comb begin
      run    = (state_d == StRun);
      tick   = run && (pre_cnt_q >= prescale);
      wrap   = tick && (cnt_q == period_act_q);
      accept = cfg_valid && !pending_q;
      apply  = pending_q && (!run || wrap);
   end

   always_comb begin
      pre_cnt_d     = pre_cnt_q;
      cnt_d         = cnt_q;
      duty_act_d    = duty_act_q;
      period_act_d  = period_act_q;
      pend_duty_d   = pend_duty_q;
      pend_period_d = pend_period_q;
      pending_d     = pending_q;
      period_end_d  = 1'b0;
      pwm_d         = 1'b0;

      if (!run) begin
         pre_cnt_d = '0;
         cnt_d     = '0;
      end else begin
         pre_cnt_d    = tick ? '0 : pre_cnt_q + 1'b1;
         period_end_d = wrap;
         pwm_d        = (cnt_q < duty_act_q);
         if (wrap) begin
            cnt_d = '0;
         end else if (tick) begin
            cnt_d = cnt_q + 1'b1;
         end
      end

      // accept needs !pending_q and apply needs pending_q, so they never coincide.
      if (apply) begin
         duty_act_d   = pend_duty_q;
         period_act_d = pend_period_q;
         pending_d    = 1'b0;
      end
      if (accept) begin
         pend_duty_d   = cfg_duty;
         pend_period_d = cfg_period;
         pending_d     = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset_p) begin
         state_q       <= StIdle;
         pre_cnt_q     <= '0;
         cnt_q         <= '0;
         duty_act_q    <= '0;
         period_act_q  <= '0;
         pend_duty_q   <= '0;
         pend_period_q <= '0;
         pending_q     <= 1'b0;
         period_end_q  <= 1'b0;
         pwm_q         <= 1'b0;
      end else begin
         state_q       <= state_d;
         pre_cnt_q     <= pre_cnt_d;
         cnt_q         <= cnt_d;
         duty_act_q    <= duty_act_d;
         period_act_q  <= period_act_d;
         pend_duty_q   <= pend_duty_d;
         pend_period_q <= pend_period_d;
         pending_q     <= pending_d;
         period_end_q  <= period_end_d;
         pwm_q         <= pwm_d;
      end
   end

   always_comb begin
      cfg_ready  = !pending_q;
      cnt        = cnt_q;
      duty_q     = duty_act_q;
      period_q   = period_act_q;
      period_end = period_end_q;
      pwm_out    = pwm_q;
   end

endmodule

// File: tb/tb_fan_pwm_timebase.sv
// Randomized and directed bench for fan_pwm_timebase, checked each cycle against a
// transaction-level model (integers plus a pending-config queue).
module tb_fan_pwm_timebase;

   logic        clk = 1'b0;
   logic        reset_p;
   logic        enable;
   logic [7:0]  prescale;
   logic        cfg_valid;
   logic        cfg_ready;
   logic [19:0] cfg_period;
   logic [19:0] cfg_duty;
   logic [19:0] cnt;
   logic [19:0] duty_q;
   logic [19:0] period_q;
   logic        period_end;
   logic        pwm_out;

   int tests = 0;
   int fails = 0;

   fan_pwm_timebase #(.N(20), .PRE_W(8)) dut (
      .clk        (clk),
      .reset_p    (reset_p),
      .enable     (enable),
      .prescale   (prescale),
      .cfg_valid  (cfg_valid),
      .cfg_ready  (cfg_ready),
      .cfg_period (cfg_period),
      .cfg_duty   (cfg_duty),
      .cnt        (cnt),
      .duty_q     (duty_q),
      .period_q   (period_q),
      .period_end (period_end),
      .pwm_out    (pwm_out)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   typedef struct {
      int unsigned period;
      int unsigned duty;
   } cfg_t;

   int unsigned m_cnt, m_phase, m_duty, m_period, m_pwm, m_pe;
   cfg_t        pend_q[$];

   // Reference: behaviour for one clock edge using the inputs sampled at that edge.
   task automatic model_step();
      cfg_t c;
      bit   acc;
      bit   tk;
      if (reset_p) begin
         m_cnt = 0; m_phase = 0; m_duty = 0; m_period = 0; m_pwm = 0; m_pe = 0;
         pend_q.delete();
         return;
      end
      acc   = cfg_valid && (pend_q.size() == 0);
      m_pwm = (enable && (m_cnt < m_duty)) ? 1 : 0;
      m_pe  = 0;
      if (!enable) begin
         m_cnt = 0;
         m_phase = 0;
         if (pend_q.size() != 0) begin
            c = pend_q.pop_front();
            m_period = c.period;
            m_duty = c.duty;
         end
      end else begin
         tk = (m_phase >= prescale);
         m_phase = tk ? 0 : m_phase + 1;
         if (tk) begin
            if (m_cnt == m_period) begin
               m_cnt = 0;
               m_pe = 1;
               if (pend_q.size() != 0) begin
                  c = pend_q.pop_front();
                  m_period = c.period;
                  m_duty = c.duty;
               end
            end else begin
               m_cnt = m_cnt + 1;
            end
         end
      end
      if (acc) pend_q.push_back('{period: cfg_period, duty: cfg_duty});
   endtask

   function automatic logic [63:0] dut_vec();
      return {1'b0, cnt, duty_q, period_q, period_end, pwm_out, cfg_ready};
   endfunction

   function automatic logic [63:0] exp_vec();
      return {1'b0, m_cnt[19:0], m_duty[19:0], m_period[19:0], m_pe[0], m_pwm[0],
              (pend_q.size() == 0)};
   endfunction

   // Inputs change on the falling edge; outputs are observed on the falling edge.
   task automatic cycle();
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   task automatic offer(input int unsigned p, input int unsigned d);
      bit ok = 0;
      cfg_period = 20'(p);
      cfg_duty   = 20'(d);
      cfg_valid  = 1'b1;
      for (int i = 0; i < 200 && !ok; i++) begin
         ok = cfg_ready;
         cycle();
      end
      cfg_valid = 1'b0;
      tests++;
      if (!ok) begin
         fails++;
         $display("FAIL handshake_accept got=no_accept exp=accept p=%0d d=%0d", p, d);
      end
   endtask

   task automatic do_reset();
      reset_p = 1'b1;
      enable = 1'b0;
      cfg_valid = 1'b0;
      prescale = 8'd0;
      cycle();
      reset_p = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      cycle();
      tests++;
      if (dut_vec() !== {1'b0, 60'd0, 3'b001}) begin
         fails++;
         $display("FAIL reset_initial got=%h exp=%h", dut_vec(), {1'b0, 60'd0, 3'b001});
      end
      offer(9, 3);
      cycle();
      enable = 1'b1;
      for (int i = 0; i < 15; i++) cycle();
      offer(9, 7);
      reset_p = 1'b1;
      cycle();
      cycle();
      tests++;
      if (dut_vec() !== {1'b0, 60'd0, 3'b001}) begin
         fails++;
         $display("FAIL reset_midrun got=%h exp=%h", dut_vec(), {1'b0, 60'd0, 3'b001});
      end
      reset_p = 1'b0;
      enable = 1'b0;
      for (int i = 0; i < 3; i++) cycle();
      tests++;
      if (duty_q !== 20'd0 || period_q !== 20'd0) begin
         fails++;
         $display("FAIL reset_pending_lost got=d%0d/p%0d exp=d0/p0", duty_q, period_q);
      end
   endtask

   task automatic test_basic_pwm();
      int pwm_hi = 0;
      int pe_cnt = 0;
      do_reset();
      offer(9, 3);
      cycle();
      enable = 1'b1;
      for (int i = 0; i < 40; i++) begin
         cycle();
         tests++;
         if (dut_vec() !== exp_vec()) begin
            fails++;
            $display("FAIL basic_cycle%0d got=%h exp=%h", i, dut_vec(), exp_vec());
         end
         if (i >= 20 && i < 30 && pwm_out) pwm_hi++;
         if (i >= 10 && period_end) pe_cnt++;
      end
      tests++;
      if (pwm_hi != 3) begin
         fails++;
         $display("FAIL basic_pwm_high got=%0d exp=3", pwm_hi);
      end
      tests++;
      if (pe_cnt != 3) begin
         fails++;
         $display("FAIL basic_period_end got=%0d exp=3", pe_cnt);
      end
   endtask

   task automatic test_prescale();
      int pe_cnt = 0;
      int last = -1;
      int gap = 0;
      do_reset();
      prescale = 8'd2;
      offer(3, 1);
      cycle();
      enable = 1'b1;
      for (int i = 0; i < 60; i++) begin
         cycle();
         tests++;
         if (dut_vec() !== exp_vec()) begin
            fails++;
            $display("FAIL prescale_cycle%0d got=%h exp=%h", i, dut_vec(), exp_vec());
         end
         if (period_end) begin
            if (last >= 0) gap = i - last;
            last = i;
            if (i >= 12) pe_cnt++;
         end
      end
      tests++;
      if (gap != 12 || pe_cnt != 4) begin
         fails++;
         $display("FAIL prescale_period got=gap%0d/n%0d exp=gap12/n4", gap, pe_cnt);
      end
   endtask

   task automatic test_update_boundary();
      bit found = 0;
      do_reset();
      offer(9, 3);
      cycle();
      enable = 1'b1;
      for (int i = 0; i < 30 && !found; i++) begin
         cycle();
         found = (cnt == 20'd5);
      end
      tests++;
      if (!found) begin
         fails++;
         $display("FAIL update_reach5 got=cnt%0d exp=cnt5", cnt);
      end
      cfg_period = 20'd9;
      cfg_duty = 20'd7;
      cfg_valid = 1'b1;
      cycle();
      cfg_valid = 1'b0;
      tests++;
      if (cfg_ready !== 1'b0) begin
         fails++;
         $display("FAIL update_ready_drop got=%b exp=0", cfg_ready);
      end
      found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         tests++;
         if (cnt != 20'd0 && duty_q !== 20'd3) begin
            fails++;
            $display("FAIL update_hold got=%0d exp=3 cnt=%0d", duty_q, cnt);
         end
         cycle();
         found = (cnt == 20'd0);
      end
      tests++;
      if (!found || duty_q !== 20'd7 || cfg_ready !== 1'b1) begin
         fails++;
         $display("FAIL update_wrap got=d%0d/r%b exp=d7/r1", duty_q, cfg_ready);
      end
   endtask

   task automatic test_edges();
      do_reset();
      offer(9, 0);
      cycle();
      enable = 1'b1;
      for (int i = 0; i < 25; i++) begin
         cycle();
         tests++;
         if (pwm_out !== 1'b0 || dut_vec() !== exp_vec()) begin
            fails++;
            $display("FAIL edge_duty0 got=%h exp=%h", dut_vec(), exp_vec());
         end
      end
      enable = 1'b0;
      offer(9, 12);
      cycle();
      enable = 1'b1;
      cycle();
      for (int i = 0; i < 25; i++) begin
         cycle();
         tests++;
         if (pwm_out !== 1'b1) begin
            fails++;
            $display("FAIL edge_duty_over got=%b exp=1", pwm_out);
         end
      end
      enable = 1'b0;
      offer(0, 0);
      cycle();
      enable = 1'b1;
      for (int i = 0; i < 10; i++) begin
         cycle();
         tests++;
         if (cnt !== 20'd0 || period_end !== 1'b1) begin
            fails++;
            $display("FAIL edge_period0 got=c%0d/pe%b exp=c0/pe1", cnt, period_end);
         end
      end
   endtask

   task automatic test_enable_drop();
      bit found = 0;
      do_reset();
      offer(9, 6);
      cycle();
      enable = 1'b1;
      for (int i = 0; i < 30 && !found; i++) begin
         cycle();
         found = (cnt == 20'd4);
      end
      enable = 1'b0;
      cycle();
      tests++;
      if (!found || cnt !== 20'd0 || pwm_out !== 1'b0) begin
         fails++;
         $display("FAIL drop_idle got=c%0d/pwm%b exp=c0/pwm0", cnt, pwm_out);
      end
      offer(5, 2);
      cycle();
      tests++;
      if (duty_q !== 20'd2 || period_q !== 20'd5 || cfg_ready !== 1'b1) begin
         fails++;
         $display("FAIL drop_apply got=d%0d/p%0d exp=d2/p5", duty_q, period_q);
      end
      enable = 1'b1;
      for (int i = 0; i < 6; i++) begin
         cycle();
         tests++;
         if (cnt !== 20'((i + 1) % 6)) begin
            fails++;
            $display("FAIL drop_restart got=%0d exp=%0d", cnt, (i + 1) % 6);
         end
      end
   endtask

   task automatic test_random();
      do_reset();
      enable = 1'b1;
      for (int i = 0; i < 2000; i++) begin
         reset_p = ($urandom_range(0, 99) == 0);
         if ($urandom_range(0, 49) == 0) enable = ~enable;
         if ($urandom_range(0, 19) == 0) prescale = 8'($urandom_range(0, 3));
         cfg_valid  = ($urandom_range(0, 9) == 0);
         cfg_period = 20'($urandom_range(0, 12));
         cfg_duty   = 20'($urandom_range(0, 14));
         cycle();
         tests++;
         if (dut_vec() !== exp_vec()) begin
            fails++;
            $display("FAIL random_cycle%0d got=%h exp=%h", i, dut_vec(), exp_vec());
         end
      end
      cfg_valid = 1'b0;
      reset_p = 1'b0;
   endtask

   initial begin
      reset_p = 1'b1;
      enable = 1'b0;
      prescale = 8'd0;
      cfg_valid = 1'b0;
      cfg_period = 20'd0;
      cfg_duty = 20'd0;
      test_reset();
      test_basic_pwm();
      test_prescale();
      test_update_boundary();
      test_edges();
      test_enable_drop();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
